xosera_bus_master: RTL and testbench
====================================

# xosera_bus_master

Host-side initiator for the Xosera 68k-style register bus. It turns a simple valid/ready register request into correctly sequenced `cs_n`/`rd_nwr`/`bytesel`/`reg_num`/data strobes, waits for Xosera's DTACK, and returns read data or a timeout. It is used in the companion host FPGA and in system-level benches to drive a real or simulated Xosera target. A 16-bit word access is issued as two byte cycles, even (high) byte first.

## Interface
- `SETUP_CYCLES`, default 1: cycles address/data/`rd_nwr` are stable before `cs_n` falls (≥1).
- `HOLD_CYCLES`, default 1: cycles address/data are held after `cs_n` rises (≥1).
- `TIMEOUT_CYCLES`, default 64: maximum cycles spent waiting in STROBE or RELEASE.
- `SYNC_STAGES`, default 2: flip-flop stages on `bus_dtack_n_i`.

Ports:
- `clk` in 1: single clock for the whole block.
- `reset_n_i` in 1: reset, asynchronous, active-low.
- `req_valid_i` in 1: request present.
- `req_ready_o` out 1: block idle and accepting.
- `req_wr_i` in 1: 1 = write, 0 = read.
- `req_reg_i` in 4: register number.
- `req_byte_i` in 1: 1 = single byte cycle, 0 = word (two cycles).
- `req_bytesel_i` in 1: byte lane for single byte cycles (0 = even/high).
- `req_data_i` in 16: write data. Byte mode uses `[7:0]`.
- `rsp_valid_o` out 1: one-cycle completion pulse.
- `rsp_data_o` out 16: read data. Byte mode returns `{8'h00, byte}`. Forced to 0 on writes and on timeout.
- `rsp_timeout_o` out 1: qualifies `rsp_valid_o`; the target failed to respond.
- `bus_cs_n_o`, `bus_rd_nwr_o`, `bus_bytesel_o` out 1: bus strobes.
- `bus_reg_num_o` out 4: bus register number.
- `bus_data_o` out 8, `bus_data_oe_o` out 1: write data and its tri-state enable.
- `bus_data_i` in 8: read data from the pins.
- `bus_dtack_n_i` in 1: asynchronous DTACK from the target, active-low.

## Operation
- All `bus_*` outputs and `rsp_*` outputs are registered.
- Reset values: `cs_n`=1, `rd_nwr`=1, `bytesel`=0, `reg_num`=0, `bus_data_o`=0, `oe`=0, `req_ready_o`=1, `rsp_valid_o`=0, `rsp_data_o`=0, `rsp_timeout_o`=0. The state is IDLE.
- **IDLE**
  - `req_ready_o`=1.
  - On `req_valid_i`, latch the request and drive `reg_num`, `rd_nwr`=!wr, and `bytesel` (0 for a word's first byte).
  - For writes, drive the data byte (`[15:8]` for a word's first byte) and set `oe`=1.
  - Go to SETUP. `req_ready_o` drops in the same edge.
- **SETUP**: count `SETUP_CYCLES`, then go to STROBE with `cs_n`=0.
- **STROBE**
  - Wait for synchronized DTACK low.
  - On that cycle, capture `bus_data_i` (reads) into the high or low half, set `cs_n`=1, and go to HOLD.
  - If the wait counter reaches `TIMEOUT_CYCLES`: set `cs_n`=1, mark the timeout, skip any remaining byte, and go to HOLD.
- **HOLD**: count `HOLD_CYCLES`, then set `oe`=0 and go to RELEASE.
- **RELEASE**
  - Wait for synchronized DTACK high, with the same timeout (marks timeout).
  - If the second byte of a word is pending and there is no timeout: go to SETUP with `bytesel`=1, and for writes data `[7:0]` with `oe`=1.
  - Otherwise go to DONE.
- **DONE**: pulse `rsp_valid_o` for one cycle with data and timeout, then return to IDLE.
- The timeout counter clears on every entry to STROBE and to RELEASE.
- A new request is never accepted before DONE completes. Requests presented while busy are held by the requester and are not dropped.
- `req_*` inputs are sampled only on the accept edge. Later changes have no effect.
- Asserting reset mid-cycle returns all outputs to their reset values immediately (asynchronously). The bus is released, with no response pulse.

## Timing
- `cs_n` falls exactly `SETUP_CYCLES` cycles after the edge that drives `reg_num`, `rd_nwr`, `bytesel` and data.
- Address, data and `oe` are unchanged from SETUP entry through the end of HOLD.
- `cs_n` is low for ≥ `SYNC_STAGES`+1 cycles whenever the target responds.
- Read data is sampled on the same edge that raises `cs_n`. This is ≥ `SYNC_STAGES` cycles after the raw DTACK fell.
- `rsp_valid_o` is asserted the cycle after RELEASE observes synchronized DTACK high on the final byte (or after its timeout). It is never asserted on the accept edge.
- Back-to-back: `req_ready_o` returns to 1 in the cycle after `rsp_valid_o`.

## Structure
- `xosera_pkg`: add the state enum `xv::busm_state_t` (IDLE, SETUP, STROBE, HOLD, RELEASE, DONE).
- Reuse the existing `xv::CS_ENABLED` and `xv::RnW_READ` for strobe polarities. Do not use literals.
- Sub-module `xosera_sync_ff`: parameterised `SYNC_STAGES` synchronizer for `bus_dtack_n_i`, with reset to 1 (deasserted).
- Counter widths are `$clog2(param+1)`.

## Test plan
- Word write, reg 3, data 16'hA55A; responder model acks 2 cycles after `cs_n` falls → two cycles with `bytesel` 0 then 1, data 8'hA5 then 8'h5A, `rd_nwr`=0, then one `rsp_valid_o` with timeout=0 and data 0.
- Word read, reg 5; model returns 8'h12 then 8'h34 → `rsp_data_o`=16'h1234, and `oe` stays 0 throughout.
- Byte read with `bytesel`=1, reg 9; model returns 8'hC7 → a single `cs_n` pulse with `bytesel`=1 and `rsp_data_o`=16'h00C7.
- No DTACK ever on a word write → `cs_n` low for `TIMEOUT_CYCLES`, only the first byte is issued, then `rsp_timeout_o`=1 with data 0, and `req_ready_o` returns to 1.
- DTACK held low after `cs_n` rises → RELEASE times out and reports a timeout; the next request, with a correct model, completes normally.
- Reset pulse while in STROBE → `cs_n`=1, `oe`=0, `req_ready_o`=1 without a clock edge, and no `rsp_valid_o`.

Source files
------------

// File: rtl/xosera_bus_master_pkg.sv
// rtl/xosera_bus_master_pkg.sv - shared strobe polarities and bus master state type
package xv;

  localparam logic CS_ENABLED = 1'b0;
  localparam logic RnW_READ   = 1'b1;
  localparam logic RnW_WRITE  = ~RnW_READ;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD,
    RELEASE,
    DONE
  } busm_state_t;

endpackage

// File: rtl/xosera_bus_master_if.sv
// rtl/xosera_bus_master_if.sv - request/response handshake and Xosera pin bundle
interface xosera_bus_master_if;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_wr_i;
  logic [3:0]  req_reg_i;
  logic        req_byte_i;
  logic        req_bytesel_i;
  logic [15:0] req_data_i;
  logic        rsp_valid_o;
  logic [15:0] rsp_data_o;
  logic        rsp_timeout_o;
  logic        bus_cs_n_o;
  logic        bus_rd_nwr_o;
  logic        bus_bytesel_o;
  logic [3:0]  bus_reg_num_o;
  logic [7:0]  bus_data_o;
  logic        bus_data_oe_o;
  logic [7:0]  bus_data_i;
  logic        bus_dtack_n_i;

  modport master (
    input  req_valid_i, req_wr_i, req_reg_i, req_byte_i, req_bytesel_i, req_data_i,
    input  bus_data_i, bus_dtack_n_i,
    output req_ready_o, rsp_valid_o, rsp_data_o, rsp_timeout_o,
    output bus_cs_n_o, bus_rd_nwr_o, bus_bytesel_o, bus_reg_num_o, bus_data_o, bus_data_oe_o
  );

  modport slave (
    output req_valid_i, req_wr_i, req_reg_i, req_byte_i, req_bytesel_i, req_data_i,
    output bus_data_i, bus_dtack_n_i,
    input  req_ready_o, rsp_valid_o, rsp_data_o, rsp_timeout_o,
    input  bus_cs_n_o, bus_rd_nwr_o, bus_bytesel_o, bus_reg_num_o, bus_data_o, bus_data_oe_o
  );
endinterface

// File: rtl/xosera_bus_master_sync_ff.sv
// rtl/xosera_bus_master_sync_ff.sv - multi-stage synchronizer, resets to deasserted (1)
module xosera_sync_ff #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n_i,
  input  logic d_i,
  output logic q_o
);

  logic [SYNC_STAGES-1:0] sync_q;

  if (SYNC_STAGES == 1) begin : g_one
    always_ff @(posedge clk or negedge reset_n_i) begin
      if (!reset_n_i) sync_q <= '1;
      else            sync_q <= d_i;
    end
  end else begin : g_chain
    always_ff @(posedge clk or negedge reset_n_i) begin
      if (!reset_n_i) sync_q <= '1;
      else            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/xosera_bus_master.sv
// rtl/xosera_bus_master.sv - valid/ready register requests to sequenced Xosera bus cycles
// Words go out as two byte cycles, even (high) byte first.
module xosera_bus_master
  import xv::*;
#(
  parameter int SETUP_CYCLES   = 1,
  parameter int HOLD_CYCLES    = 1,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int SYNC_STAGES    = 2
) (
  input logic                 clk,
  input logic                 reset_n_i,
  xosera_bus_master_if.master bus
);

  localparam int PH_MAX = (SETUP_CYCLES > HOLD_CYCLES) ? SETUP_CYCLES : HOLD_CYCLES;
  localparam int PW     = $clog2(PH_MAX + 1);
  localparam int TW     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [PW-1:0] SETUP_LAST = PW'(SETUP_CYCLES - 1);
  localparam logic [PW-1:0] HOLD_LAST  = PW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT_CYCLES - 1);

  busm_state_t   state_q, state_d;
  logic [PW-1:0] ph_q, ph_d;
  logic [TW-1:0] to_q, to_d;
  logic          wr_q, wr_d;
  logic          pend_q, pend_d;
  logic [7:0]    lo_q, lo_d;
  logic [15:0]   rdata_q, rdata_d;
  logic          tmo_q, tmo_d;
  logic          cs_n_q, cs_n_d;
  logic          rnw_q, rnw_d;
  logic          bsel_q, bsel_d;
  logic [3:0]    reg_q, reg_d;
  logic [7:0]    dout_q, dout_d;
  logic          oe_q, oe_d;
  logic          ready_q, ready_d;
  logic          rvalid_q, rvalid_d;
  logic [15:0]   rsp_data_q, rsp_data_d;
  logic          rsp_to_q, rsp_to_d;
  logic          dtack_n_s;

  xosera_sync_ff #(.SYNC_STAGES(SYNC_STAGES)) u_dtack_sync (
    .clk       (clk),
    .reset_n_i (reset_n_i),
    .d_i       (bus.bus_dtack_n_i),
    .q_o       (dtack_n_s)
  );

  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q    <= IDLE;
      ph_q       <= '0;
      to_q       <= '0;
      wr_q       <= 1'b0;
      pend_q     <= 1'b0;
      lo_q       <= '0;
      rdata_q    <= '0;
      tmo_q      <= 1'b0;
      cs_n_q     <= ~CS_ENABLED;
      rnw_q      <= RnW_READ;
      bsel_q     <= 1'b0;
      reg_q      <= '0;
      dout_q     <= '0;
      oe_q       <= 1'b0;
      ready_q    <= 1'b1;
      rvalid_q   <= 1'b0;
      rsp_data_q <= '0;
      rsp_to_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      ph_q       <= ph_d;
      to_q       <= to_d;
      wr_q       <= wr_d;
      pend_q     <= pend_d;
      lo_q       <= lo_d;
      rdata_q    <= rdata_d;
      tmo_q      <= tmo_d;
      cs_n_q     <= cs_n_d;
      rnw_q      <= rnw_d;
      bsel_q     <= bsel_d;
      reg_q      <= reg_d;
      dout_q     <= dout_d;
      oe_q       <= oe_d;
      ready_q    <= ready_d;
      rvalid_q   <= rvalid_d;
      rsp_data_q <= rsp_data_d;
      rsp_to_q   <= rsp_to_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ph_d       = ph_q;
    to_d       = to_q;
    wr_d       = wr_q;
    pend_d     = pend_q;
    lo_d       = lo_q;
    rdata_d    = rdata_q;
    tmo_d      = tmo_q;
    cs_n_d     = cs_n_q;
    rnw_d      = rnw_q;
    bsel_d     = bsel_q;
    reg_d      = reg_q;
    dout_d     = dout_q;
    oe_d       = oe_q;
    ready_d    = ready_q;
    rvalid_d   = 1'b0;
    rsp_data_d = rsp_data_q;
    rsp_to_d   = rsp_to_q;

    unique case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        if (bus.req_valid_i) begin
          wr_d    = bus.req_wr_i;
          pend_d  = ~bus.req_byte_i;
          lo_d    = bus.req_data_i[7:0];
          rdata_d = '0;
          tmo_d   = 1'b0;
          reg_d   = bus.req_reg_i;
          rnw_d   = bus.req_wr_i ? RnW_WRITE : RnW_READ;
          bsel_d  = bus.req_byte_i ? bus.req_bytesel_i : 1'b0;
          if (!bus.req_wr_i)      dout_d = '0;
          else if (bus.req_byte_i) dout_d = bus.req_data_i[7:0];
          else                     dout_d = bus.req_data_i[15:8];
          oe_d    = bus.req_wr_i;
          ph_d    = '0;
          ready_d = 1'b0;
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (ph_q == SETUP_LAST) begin
          cs_n_d  = CS_ENABLED;
          to_d    = '0;
          state_d = STROBE;
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end
      STROBE: begin
        if (!dtack_n_s) begin
          // pend_q still set means this is the first (high) byte of a word
          if (!wr_q) begin
            if (pend_q) rdata_d[15:8] = bus.bus_data_i;
            else        rdata_d[7:0]  = bus.bus_data_i;
          end
          cs_n_d  = ~CS_ENABLED;
          ph_d    = '0;
          state_d = HOLD;
        end else if (to_q == TO_LAST) begin
          cs_n_d  = ~CS_ENABLED;
          tmo_d   = 1'b1;
          pend_d  = 1'b0;
          ph_d    = '0;
          state_d = HOLD;
        end else begin
          to_d = to_q + 1'b1;
        end
      end
      HOLD: begin
        if (ph_q == HOLD_LAST) begin
          oe_d    = 1'b0;
          to_d    = '0;
          state_d = RELEASE;
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end
      RELEASE: begin
        if (dtack_n_s && pend_q && !tmo_q) begin
          pend_d  = 1'b0;
          bsel_d  = 1'b1;
          dout_d  = wr_q ? lo_q : 8'h00;
          oe_d    = wr_q;
          ph_d    = '0;
          state_d = SETUP;
        end else if (dtack_n_s || to_q == TO_LAST) begin
          rvalid_d   = 1'b1;
          rsp_to_d   = tmo_q | ~dtack_n_s;
          rsp_data_d = (wr_q || tmo_q || !dtack_n_s) ? 16'h0000 : rdata_q;
          state_d    = DONE;
        end else begin
          to_d = to_q + 1'b1;
        end
      end
      DONE: begin
        ready_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.req_ready_o   = ready_q;
  assign bus.rsp_valid_o   = rvalid_q;
  assign bus.rsp_data_o    = rsp_data_q;
  assign bus.rsp_timeout_o = rsp_to_q;
  assign bus.bus_cs_n_o    = cs_n_q;
  assign bus.bus_rd_nwr_o  = rnw_q;
  assign bus.bus_bytesel_o = bsel_q;
  assign bus.bus_reg_num_o = reg_q;
  assign bus.bus_data_o    = dout_q;
  assign bus.bus_data_oe_o = oe_q;

endmodule

// File: tb/tb_xosera_bus_master.sv
// tb/tb_xosera_bus_master.sv - directed table, corner sequences and random requests vs a transaction model
module tb_xosera_bus_master;

  localparam int SETUP = 2;
  localparam int HOLD  = 2;
  localparam int TMO   = 16;
  localparam int SYNC  = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  xosera_bus_master_if bif ();

  xosera_bus_master #(
    .SETUP_CYCLES   (SETUP),
    .HOLD_CYCLES    (HOLD),
    .TIMEOUT_CYCLES (TMO),
    .SYNC_STAGES    (SYNC)
  ) dut (
    .clk       (clk),
    .reset_n_i (reset_n),
    .bus       (bif)
  );

  typedef struct {
    logic        wr;
    logic [3:0]  rg;
    logic        byt;
    logic        bs;
    logic [15:0] d;
    logic        ack;
    int          dly;
    logic [7:0]  rhi;
    logic [7:0]  rlo;
    logic [15:0] ed;
    logic        eto;
  } vec_t;

  typedef struct {
    logic [3:0] rg;
    logic       bs;
    logic       rnw;
    logic [7:0] dat;
    logic       oe;
    int         len;
  } cyc_t;

  int total = 0;
  int bad = 0;
  cyc_t obs_q[$];
  cyc_t exp_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // target responder: acks dly cycles after cs_n falls, returns rhi/rlo by byte lane
  logic       ack_en = 1'b1;
  logic       stuck = 1'b0;
  int         dly = 0;
  logic [7:0] rhi = 8'h00;
  logic [7:0] rlo = 8'h00;
  int         low_cnt = 0;

  always @(posedge clk) begin
    #1;
    if (!reset_n) begin
      bif.bus_dtack_n_i = 1'b1;
      bif.bus_data_i    = 8'h00;
      low_cnt = 0;
    end else if (bif.bus_cs_n_o == 1'b0) begin
      if (ack_en && low_cnt == dly) begin
        bif.bus_dtack_n_i = 1'b0;
        bif.bus_data_i    = bif.bus_bytesel_o ? rlo : rhi;
      end
      low_cnt++;
    end else begin
      low_cnt = 0;
      if (!stuck) bif.bus_dtack_n_i = 1'b1;
    end
  end

  // bus monitor: records each cs_n pulse and checks setup/stability/hold timing
  int          cyc = 0;
  int          launch_cyc = 0;
  int          fall_cyc = 0;
  int          rise_cyc = 0;
  logic        p_cs = 1'b1;
  logic        p_ready = 1'b1;
  logic        p_oe = 1'b0;
  logic [15:0] p_fields = '0;
  logic [15:0] fields;
  logic        stable = 1'b1;
  cyc_t        cur;

  always @(negedge clk) begin
    cyc++;
    fields = {1'b0, bif.bus_reg_num_o, bif.bus_bytesel_o, bif.bus_rd_nwr_o, bif.bus_data_o, bif.bus_data_oe_o};
    if (!reset_n) begin
      p_cs = 1'b1;
      p_ready = 1'b1;
      p_oe = 1'b0;
      p_fields = fields;
    end else begin
      if ((p_ready && !bif.req_ready_o) || (bif.bus_cs_n_o && fields[15:1] != p_fields[15:1]))
        launch_cyc = cyc;
      if (p_cs && !bif.bus_cs_n_o) begin
        chk("setup_cycles", cyc - launch_cyc, SETUP);
        cur.rg  = bif.bus_reg_num_o;
        cur.bs  = bif.bus_bytesel_o;
        cur.rnw = bif.bus_rd_nwr_o;
        cur.dat = bif.bus_data_o;
        cur.oe  = bif.bus_data_oe_o;
        fall_cyc = cyc;
        stable = 1'b1;
      end
      if (!bif.bus_cs_n_o && fields != {1'b0, cur.rg, cur.bs, cur.rnw, cur.dat, cur.oe})
        stable = 1'b0;
      if (!p_cs && bif.bus_cs_n_o) begin
        chk("strobe_stable", stable, 1);
        cur.len = cyc - fall_cyc;
        obs_q.push_back(cur);
        rise_cyc = cyc;
      end
      if (p_oe && !bif.bus_data_oe_o)
        chk("oe_hold_cycles", cyc - rise_cyc, HOLD);
      p_cs = bif.bus_cs_n_o;
      p_ready = bif.req_ready_o;
      p_oe = bif.bus_data_oe_o;
      p_fields = fields;
    end
  end

  function automatic vec_t mk(logic wr, logic [3:0] rg, logic byt, logic bs, logic [15:0] d,
                              logic ack, int dl, logic [7:0] hi, logic [7:0] lo,
                              logic [15:0] ed, logic eto);
    vec_t v;
    v.wr = wr; v.rg = rg; v.byt = byt; v.bs = bs; v.d = d; v.ack = ack; v.dly = dl;
    v.rhi = hi; v.rlo = lo; v.ed = ed; v.eto = eto;
    return v;
  endfunction

  // transaction-level model: which byte cycles appear and what the response is
  task automatic model(input vec_t v, output logic [15:0] ed, output logic eto);
    int   n;
    cyc_t c;
    exp_q.delete();
    n = (v.byt || !v.ack) ? 1 : 2;
    for (int i = 0; i < n; i++) begin
      c.rg  = v.rg;
      c.bs  = v.byt ? v.bs : (i == 1);
      c.rnw = !v.wr;
      c.oe  = v.wr;
      c.dat = !v.wr ? 8'h00 : ((v.byt || i == 1) ? v.d[7:0] : v.d[15:8]);
      c.len = v.ack ? v.dly + SYNC + 1 : TMO;
      exp_q.push_back(c);
    end
    eto = !v.ack;
    if (v.wr || !v.ack) ed = 16'h0000;
    else if (v.byt)     ed = {8'h00, v.bs ? v.rlo : v.rhi};
    else                ed = {v.rhi, v.rlo};
  endtask

  task automatic check_cycles(input string tag);
    chk($sformatf("%s_ncyc", tag), obs_q.size(), exp_q.size());
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      chk($sformatf("%s_c%0d_reg", tag, i), obs_q[i].rg, exp_q[i].rg);
      chk($sformatf("%s_c%0d_bsel", tag, i), obs_q[i].bs, exp_q[i].bs);
      chk($sformatf("%s_c%0d_rnw", tag, i), obs_q[i].rnw, exp_q[i].rnw);
      chk($sformatf("%s_c%0d_oe", tag, i), obs_q[i].oe, exp_q[i].oe);
      chk($sformatf("%s_c%0d_len", tag, i), obs_q[i].len, exp_q[i].len);
      if (exp_q[i].oe) chk($sformatf("%s_c%0d_dat", tag, i), obs_q[i].dat, exp_q[i].dat);
    end
  endtask

  task automatic issue(input vec_t v);
    logic acc;
    ack_en = v.ack; dly = v.dly; rhi = v.rhi; rlo = v.rlo;
    obs_q.delete();
    @(posedge clk); #1;
    bif.req_valid_i   = 1'b1;
    bif.req_wr_i      = v.wr;
    bif.req_reg_i     = v.rg;
    bif.req_byte_i    = v.byt;
    bif.req_bytesel_i = v.bs;
    bif.req_data_i    = v.d;
    acc = 1'b0;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(posedge clk); #1;
      if (!bif.req_ready_o) acc = 1'b1;
    end
    chk("accepted", acc, 1);
    chk("no_rsp_on_accept", bif.rsp_valid_o, 0);
    bif.req_valid_i   = 1'b0;
    bif.req_wr_i      = 1'($urandom);
    bif.req_reg_i     = 4'($urandom);
    bif.req_byte_i    = 1'($urandom);
    bif.req_bytesel_i = 1'($urandom);
    bif.req_data_i    = 16'($urandom);
  endtask

  task automatic run_req(input vec_t v, output logic [15:0] rd, output logic rto);
    logic got, oe_seen;
    issue(v);
    got = 1'b0; oe_seen = 1'b0; rd = 'x; rto = 'x;
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge clk);
      if (bif.bus_data_oe_o) oe_seen = 1'b1;
      if (bif.rsp_valid_o) begin
        got = 1'b1;
        rd  = bif.rsp_data_o;
        rto = bif.rsp_timeout_o;
      end
    end
    chk("rsp_seen", got, 1);
    chk("oe_only_on_write", oe_seen, v.wr);
    @(negedge clk);
    chk("rsp_one_cycle", bif.rsp_valid_o, 0);
    chk("ready_after_rsp", bif.req_ready_o, 1);
  endtask

  vec_t        vt[7];
  vec_t        v;
  logic [15:0] ed, rd;
  logic        eto, rto, flag;
  int          pulses;

  initial begin
    bif.req_valid_i = 1'b0; bif.req_wr_i = 1'b0; bif.req_reg_i = '0;
    bif.req_byte_i = 1'b0; bif.req_bytesel_i = 1'b0; bif.req_data_i = '0;

    vt[0] = mk(1, 4'd3, 0, 0, 16'hA55A, 1, 2, 8'h00, 8'h00, 16'h0000, 0);
    vt[1] = mk(0, 4'd5, 0, 0, 16'h0000, 1, 1, 8'h12, 8'h34, 16'h1234, 0);
    vt[2] = mk(0, 4'd9, 1, 1, 16'h0000, 1, 0, 8'h00, 8'hC7, 16'h00C7, 0);
    vt[3] = mk(1, 4'hC, 0, 0, 16'h3C96, 0, 0, 8'h00, 8'h00, 16'h0000, 1);
    vt[4] = mk(1, 4'hF, 1, 0, 16'h77BE, 1, 3, 8'h00, 8'h00, 16'h0000, 0);
    vt[5] = mk(0, 4'd2, 1, 0, 16'h0000, 1, 4, 8'h9E, 8'h11, 16'h009E, 0);
    vt[6] = mk(0, 4'd0, 0, 0, 16'h0000, 1, 0, 8'hFF, 8'h00, 16'hFF00, 0);

    repeat (3) @(negedge clk);
    chk("rst_cs_n", bif.bus_cs_n_o, 1);
    chk("rst_rd_nwr", bif.bus_rd_nwr_o, 1);
    chk("rst_bytesel", bif.bus_bytesel_o, 0);
    chk("rst_reg_num", bif.bus_reg_num_o, 0);
    chk("rst_data", bif.bus_data_o, 0);
    chk("rst_oe", bif.bus_data_oe_o, 0);
    chk("rst_ready", bif.req_ready_o, 1);
    chk("rst_rsp_valid", bif.rsp_valid_o, 0);
    chk("rst_rsp_data", bif.rsp_data_o, 0);
    chk("rst_rsp_timeout", bif.rsp_timeout_o, 0);
    @(posedge clk); #1; reset_n = 1'b1;
    repeat (3) @(posedge clk);

    for (int i = 0; i < 7; i++) begin
      model(vt[i], ed, eto);
      run_req(vt[i], rd, rto);
      chk($sformatf("vec%0d_data", i), rd, vt[i].ed);
      chk($sformatf("vec%0d_timeout", i), rto, vt[i].eto);
      check_cycles($sformatf("vec%0d", i));
    end

    // DTACK stuck low after cs_n rises: release phase times out, second byte skipped
    stuck = 1'b1;
    v = mk(0, 4'd7, 0, 0, 16'h0000, 1, 1, 8'hAB, 8'hCD, 16'h0000, 1);
    exp_q.delete();
    exp_q.push_back('{rg: 4'd7, bs: 1'b0, rnw: 1'b1, dat: 8'h00, oe: 1'b0, len: 1 + SYNC + 1});
    run_req(v, rd, rto);
    chk("stuck_data", rd, 16'h0000);
    chk("stuck_timeout", rto, 1);
    check_cycles("stuck");
    stuck = 1'b0;
    repeat (6) @(posedge clk);
    v = mk(0, 4'd7, 0, 0, 16'h0000, 1, 2, 8'h5A, 8'hA5, 16'h5AA5, 0);
    model(v, ed, eto);
    run_req(v, rd, rto);
    chk("after_stuck_data", rd, 16'h5AA5);
    chk("after_stuck_timeout", rto, 0);
    check_cycles("after_stuck");

    // asynchronous reset while cs_n is low
    v = mk(1, 4'd6, 1, 0, 16'h00E1, 0, 0, 8'h00, 8'h00, 16'h0000, 1);
    issue(v);
    flag = 1'b0;
    for (int i = 0; i < 20 && !flag; i++) begin
      @(posedge clk); #1;
      if (!bif.bus_cs_n_o) flag = 1'b1;
    end
    chk("rst_mid_reached_strobe", flag, 1);
    chk("rst_mid_pre_oe", bif.bus_data_oe_o, 1);
    @(posedge clk); #3;
    reset_n = 1'b0;
    #1;
    chk("rst_mid_cs_n", bif.bus_cs_n_o, 1);
    chk("rst_mid_oe", bif.bus_data_oe_o, 0);
    chk("rst_mid_ready", bif.req_ready_o, 1);
    chk("rst_mid_rsp_valid", bif.rsp_valid_o, 0);
    repeat (2) @(negedge clk);
    @(posedge clk); #1; reset_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bif.rsp_valid_o) pulses++;
    end
    chk("rst_mid_no_rsp", pulses, 0);
    chk("rst_mid_ready_after", bif.req_ready_o, 1);
    chk("rst_mid_cs_after", bif.bus_cs_n_o, 1);

    for (int i = 0; i < 40; i++) begin
      v = mk(1'($urandom), 4'($urandom), 1'($urandom), 1'($urandom), 16'($urandom),
             ($urandom_range(0, 7) != 0), $urandom_range(0, 4), 8'($urandom), 8'($urandom),
             16'h0000, 1'b0);
      model(v, ed, eto);
      run_req(v, rd, rto);
      chk($sformatf("rnd%0d_data", i), rd, ed);
      chk($sformatf("rnd%0d_timeout", i), rto, eto);
      check_cycles($sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
